sevenseg_scan_pwm: RTL

- Parametrised N-digit multiplexed seven-segment driver with the same function as the team's existing 4-digit scanner.
- Adds:
  - runtime scan-rate divider
  - full hex decode
  - per-digit decimal point and blanking
  - leading-zero suppression
  - PWM brightness control
  - anti-ghost guard
  - atomic frame-synchronous display update via load/pending handshake
- Sits between the PWM controller's status/readout logic and the board display pins.

---
 rtl/sevenseg_pkg.sv | 15 +
 rtl/sevenseg_hex_decode.sv | 11 +
 rtl/sevenseg_scan_pwm.sv | 113 +++++++++++
 3 files changed

// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: segment decode table, blank pattern and pin-polarity helper
package sevenseg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] seg_pol(input logic [6:0] pattern, input bit active_low);
        return active_low ? ~pattern : pattern;
    endfunction

endpackage

// File: rtl/sevenseg_hex_decode.sv
// sevenseg_hex_decode: nibble to active-high gfedcba segment pattern
module sevenseg_hex_decode
    import sevenseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/sevenseg_scan_pwm.sv
// sevenseg_scan_pwm: multiplexed N-digit seven-segment scanner with PWM dimming and frame-synchronous updates
module sevenseg_scan_pwm
    import sevenseg_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int DIV_W      = 18,
    parameter int BRIGHT_W   = 4,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic                  load,
    input  logic [DIV_W-1:0]      tick_div,
    input  logic [BRIGHT_W-1:0]   brightness,
    input  logic                  lz_suppress,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_start,
    output logic                  pending
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

    logic [DIV_W-1:0]    pre;
    logic [IDX_W-1:0]    idx;
    logic [BRIGHT_W-1:0] pwm_cnt;
    logic                tick, tick_q, wrap;
    logic [4*DIGITS-1:0] stg_digits, act_digits;
    logic [DIGITS-1:0]   stg_dp, act_dp, stg_blank, act_blank;
    logic [3:0]          nibble;
    logic [6:0]          pattern;
    logic                lz_dark, pwm_on;
    logic [DIGITS-1:0]   an_sel;

    assign tick   = pre >= tick_div;
    assign wrap   = tick && idx == LAST;
    assign nibble = act_digits[4*idx +: 4];
    assign pwm_on = pwm_cnt < brightness || &brightness;
    assign an_sel = (!tick_q && pwm_on) ? DIGITS'(1) << idx : '0;

    sevenseg_hex_decode u_dec (
        .nibble (nibble),
        .seg    (pattern)
    );

    // current digit is a suppressed leading zero when it and every digit above it are zero
    always_comb begin
        lz_dark = lz_suppress && idx != '0;
        for (int i = 0; i < DIGITS; i++)
            if (IDX_W'(i) >= idx && act_digits[4*i +: 4] != 4'd0) lz_dark = 1'b0;
    end

    // prescaler, digit scan, free-running PWM counter and frame pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre         <= '0;
            idx         <= '0;
            pwm_cnt     <= '0;
            tick_q      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pre         <= tick ? '0 : pre + DIV_W'(1);
            idx         <= tick ? (idx == LAST ? '0 : idx + IDX_W'(1)) : idx;
            pwm_cnt     <= pwm_cnt + BRIGHT_W'(1);
            tick_q      <= tick;
            frame_start <= wrap;
        end
    end

    // staging captures on load; active takes staging only at the frame wrap so a frame is never torn
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stg_digits <= '0;
            stg_dp     <= '0;
            stg_blank  <= '1;
            act_digits <= '0;
            act_dp     <= '0;
            act_blank  <= '1;
            pending    <= 1'b0;
        end else begin
            if (wrap && pending) begin
                act_digits <= stg_digits;
                act_dp     <= stg_dp;
                act_blank  <= stg_blank;
            end
            if (load) begin
                stg_digits <= digits_in;
                stg_dp     <= dp_in;
                stg_blank  <= blank_in;
            end
            pending <= load || (pending && !wrap);
        end
    end

    // registered pins; anodes are dark for the guard cycle after each tick while segments settle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seg <= seg_pol(SEG_BLANK, ACTIVE_LOW);
            dp  <= ACTIVE_LOW;
            an  <= {DIGITS{ACTIVE_LOW}};
        end else begin
            seg <= seg_pol((act_blank[idx] || lz_dark) ? SEG_BLANK : pattern, ACTIVE_LOW);
            dp  <= (act_dp[idx] && !act_blank[idx]) ^ ACTIVE_LOW;
            an  <= an_sel ^ {DIGITS{ACTIVE_LOW}};
        end
    end

endmodule
